// File: rtl/chirp_sweep_gen.sv
// rtl/chirp_sweep_gen.sv - linear chirp generator: NCO phase accumulator with stepped increment
// Up/down/triangle sweeps between latched bounds, one-shot or looped, square/saw/triangle outputs.
module chirp_sweep_gen #(
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 16,
  parameter int DWELL_W = 12,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  input  logic               loop_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [FREQ_W-1:0]  freq_cur,
  output logic               wave_sq,
  output logic [OUT_W-1:0]   wave_saw,
  output logic [OUT_W-1:0]   wave_tri
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [FREQ_W-1:0]    freq_q, freq_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [FREQ_W-1:0]    lo_q, lo_d;
  logic [FREQ_W-1:0]    hi_q, hi_d;
  logic [FREQ_W-1:0]    stp_q, stp_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 tri_q, tri_d;

  // One extra bit so bound comparisons never see a wrapped sum.
  logic [FREQ_W:0]      sum_up;
  logic [FREQ_W:0]      lo_plus;
  logic                 tick;
  logic                 finish;

  assign sum_up  = {1'b0, freq_q} + {1'b0, stp_q};
  assign lo_plus = {1'b0, lo_q} + {1'b0, stp_q};
  assign tick    = (cnt_q == dwell_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      freq_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      stp_q   <= '0;
      dwell_q <= '0;
      tri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      stp_q   <= stp_d;
      dwell_q <= dwell_d;
      tri_q   <= tri_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    stp_d   = stp_q;
    dwell_d = dwell_q;
    tri_d   = tri_q;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((f_step == '0) || (f_start > f_stop)) begin
            err_d = 1'b1;
          end else begin
            lo_d    = f_start;
            hi_d    = f_stop;
            stp_d   = f_step;
            dwell_d = dwell;
            tri_d   = (mode == 2'b10);
            phase_d = '0;
            cnt_d   = '0;
            if (mode == 2'b01) begin
              state_d = RUN_DN;
              freq_d  = f_stop;
            end else begin
              state_d = RUN_UP;
              freq_d  = f_start;
            end
          end
        end
      end

      RUN_UP, RUN_DN: begin
        phase_d = phase_q + PHASE_W'(freq_q);
        cnt_d   = tick ? '0 : cnt_q + DWELL_W'(1);
        // A dwell tick taken while already sitting on the bound is the endpoint.
        if (tick) begin
          if (state_q == RUN_UP) begin
            if (freq_q == hi_q) begin
              if (tri_q) begin
                state_d = RUN_DN;
              end else if (loop_en) begin
                freq_d = lo_q;
              end else begin
                finish = 1'b1;
              end
            end else if (sum_up >= {1'b0, hi_q}) begin
              freq_d = hi_q;
            end else begin
              freq_d = sum_up[FREQ_W-1:0];
            end
          end else begin
            if (freq_q == lo_q) begin
              if (loop_en) begin
                state_d = tri_q ? RUN_UP : RUN_DN;
                freq_d  = tri_q ? freq_q : hi_q;
              end else begin
                finish = 1'b1;
              end
            end else if ({1'b0, freq_q} < lo_plus) begin
              freq_d = lo_q;
            end else begin
              freq_d = freq_q - stp_q;
            end
          end
        end

        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
          phase_d = '0;
          freq_d  = '0;
          cnt_d   = '0;
        end

        // Abort overrides any endpoint decided in the same cycle.
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
          phase_d = '0;
          freq_d  = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
        freq_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign freq_cur = freq_q;
  assign wave_sq  = phase_q[PHASE_W-1];
  assign wave_saw = phase_q[PHASE_W-1 -: OUT_W];
  assign wave_tri = phase_q[PHASE_W-1] ? ~phase_q[PHASE_W-2 -: OUT_W]
                                       :  phase_q[PHASE_W-2 -: OUT_W];

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// tb/tb_chirp_sweep_gen.sv - directed self-checking bench for chirp_sweep_gen
module tb_chirp_sweep_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort, loop_en;
  logic [15:0] f_start, f_stop, f_step;
  logic [11:0] dwell;
  logic [1:0]  mode;
  logic        busy, done, err, wave_sq;
  logic [15:0] freq_cur;
  logic [7:0]  wave_saw, wave_tri;

  int errors = 0;
  int checks = 0;

  chirp_sweep_gen #(.PHASE_W(16), .FREQ_W(16), .DWELL_W(12), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .mode(mode), .loop_en(loop_en),
    .busy(busy), .done(done), .err(err), .freq_cur(freq_cur),
    .wave_sq(wave_sq), .wave_saw(wave_saw), .wave_tri(wave_tri)
  );

  always #5 clk = ~clk;

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] st,
                     input logic [11:0] dw, input logic [1:0] md, input logic lp);
    f_start = lo; f_stop = hi; f_step = st; dwell = dw; mode = md; loop_en = lp;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
    checks++;
    if ({busy, done, err, freq_cur, wave_sq, wave_saw, wave_tri} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b freq=%0d sq=%0b saw=%0h tri=%0h, expected all 0",
               busy, done, err, freq_cur, wave_sq, wave_saw, wave_tri);
    end
  endtask

  task automatic test_up_oneshot;
    logic [15:0] ph;
    logic [15:0] ef;
    cfg(16'd100, 16'd400, 16'd100, 12'd3, 2'b00, 1'b0);
    pulse_start();
    ph = 16'h0;
    for (int i = 0; i < 16; i++) begin
      ef = 16'(100 * (i / 4 + 1));
      checks++;
      if (freq_cur !== ef || busy !== 1'b1 || done !== 1'b0 || wave_saw !== ph[15:8]) begin
        errors++;
        $display("FAIL up_step%0d: got freq=%0d busy=%0b done=%0b saw=%0h, expected freq=%0d busy=1 done=0 saw=%0h",
                 i, freq_cur, busy, done, wave_saw, ef, ph[15:8]);
      end
      ph = ph + ef;
      step_clk();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || freq_cur !== 16'd0 || wave_saw !== 8'd0) begin
      errors++;
      $display("FAIL up_done: got busy=%0b done=%0b freq=%0d saw=%0h, expected busy=0 done=1 freq=0 saw=0",
               busy, done, freq_cur, wave_saw);
    end
    step_clk();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL up_done_pulse: got done=%0b, expected 0", done);
    end
  endtask

  task automatic test_triangle_loop;
    int seq [8] = '{100, 200, 300, 400, 400, 300, 200, 100};
    logic [15:0] ph;
    logic [15:0] ef;
    cfg(16'd100, 16'd400, 16'd100, 12'd3, 2'b10, 1'b1);
    pulse_start();
    ph = 16'h0;
    for (int i = 0; i < 80; i++) begin
      ef = 16'(seq[(i / 4) % 8]);
      checks++;
      if (freq_cur !== ef || busy !== 1'b1 || done !== 1'b0 || wave_saw !== ph[15:8]) begin
        errors++;
        $display("FAIL tri_cycle%0d: got freq=%0d busy=%0b done=%0b saw=%0h, expected freq=%0d busy=1 done=0 saw=%0h",
                 i, freq_cur, busy, done, wave_saw, ef, ph[15:8]);
      end
      ph = ph + ef;
      step_clk();
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || freq_cur !== 16'd0 || wave_saw !== 8'd0) begin
      errors++;
      $display("FAIL tri_abort: got busy=%0b done=%0b freq=%0d saw=%0h, expected busy=0 done=0 freq=0 saw=0",
               busy, done, freq_cur, wave_saw);
    end
    step_clk();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tri_abort_nodone: got busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_down_clamp;
    int exp_f [4] = '{100, 60, 20, 10};
    cfg(16'd10, 16'd100, 16'd40, 12'd0, 2'b01, 1'b0);
    abort = 1'b1;
    step_clk();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort: got busy=%0b done=%0b err=%0b, expected 0 0 0", busy, done, err);
    end
    start = 1'b1;
    step_clk();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (freq_cur !== 16'(exp_f[i]) || busy !== 1'b1) begin
        errors++;
        $display("FAIL down_step%0d: got freq=%0d busy=%0b, expected freq=%0d busy=1",
                 i, freq_cur, busy, exp_f[i]);
      end
      step_clk();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || freq_cur !== 16'd0) begin
      errors++;
      $display("FAIL down_done: got busy=%0b done=%0b freq=%0d, expected busy=0 done=1 freq=0",
               busy, done, freq_cur);
    end
    step_clk();
  endtask

  task automatic test_reject;
    cfg(16'd5, 16'd400, 16'd0, 12'd1, 2'b00, 1'b0);
    pulse_start();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_step0: got err=%0b busy=%0b, expected err=1 busy=0", err, busy);
    end
    step_clk();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_step0_pulse: got err=%0b busy=%0b, expected 0 0", err, busy);
    end
    cfg(16'd500, 16'd400, 16'd1, 12'd1, 2'b00, 1'b0);
    pulse_start();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_order: got err=%0b busy=%0b, expected err=1 busy=0", err, busy);
    end
    step_clk();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_order_pulse: got err=%0b busy=%0b, expected 0 0", err, busy);
    end
  endtask

  task automatic test_equal_bounds;
    cfg(16'd50, 16'd50, 16'd1, 12'd1, 2'b00, 1'b0);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (freq_cur !== 16'd50 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL equal_hold%0d: got freq=%0d busy=%0b done=%0b, expected 50 1 0",
                 i, freq_cur, busy, done);
      end
      step_clk();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL equal_done: got done=%0b busy=%0b, expected 1 0", done, busy);
    end
    step_clk();
  endtask

  task automatic test_phase_wrap;
    logic [7:0] saw_e [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
    logic [7:0] tri_e [4] = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    logic       sq_e  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    cfg(16'h4000, 16'h4000, 16'd1, 12'd100, 2'b00, 1'b1);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (wave_saw !== saw_e[i % 4] || wave_tri !== tri_e[i % 4] || wave_sq !== sq_e[i % 4] ||
          freq_cur !== 16'h4000) begin
        errors++;
        $display("FAIL wrap%0d: got saw=%0h tri=%0h sq=%0b freq=%0h, expected saw=%0h tri=%0h sq=%0b freq=4000",
                 i, wave_saw, wave_tri, wave_sq, freq_cur, saw_e[i % 4], tri_e[i % 4], sq_e[i % 4]);
      end
      step_clk();
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || wave_saw !== 8'd0) begin
      errors++;
      $display("FAIL wrap_abort: got busy=%0b saw=%0h, expected 0 0", busy, wave_saw);
    end
  endtask

  task automatic test_reset_and_busy_start;
    cfg(16'd100, 16'd400, 16'd100, 12'd3, 2'b00, 1'b1);
    pulse_start();
    for (int i = 0; i < 5; i++) step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    checks++;
    if ({busy, done, err, freq_cur, wave_sq, wave_saw, wave_tri} !== 36'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%0b done=%0b err=%0b freq=%0d sq=%0b saw=%0h tri=%0h, expected all 0",
               busy, done, err, freq_cur, wave_sq, wave_saw, wave_tri);
    end
    step_clk();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got busy=%0b done=%0b err=%0b, expected 0 0 0", busy, done, err);
    end
    pulse_start();
    step_clk();
    step_clk();
    f_step = 16'd0;
    f_stop = 16'd900;
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || freq_cur !== 16'd100) begin
      errors++;
      $display("FAIL busy_start: got err=%0b busy=%0b freq=%0d, expected err=0 busy=1 freq=100",
               err, busy, freq_cur);
    end
    step_clk();
    checks++;
    if (freq_cur !== 16'd200 || err !== 1'b0) begin
      errors++;
      $display("FAIL latched_cfg: got freq=%0d err=%0b, expected freq=200 err=0", freq_cur, err);
    end
    loop_en = 1'b0;
    for (int i = 0; i < 12; i++) step_clk();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_clear_done: got done=%0b busy=%0b, expected 1 0", done, busy);
    end
    step_clk();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg(16'd0, 16'd0, 16'd0, 12'd0, 2'b00, 1'b0);
    test_reset();
    test_up_oneshot();
    test_triangle_loop();
    test_down_clamp();
    test_reject();
    test_equal_bounds();
    test_phase_wrap();
    test_reset_and_busy_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
